// File: rtl/serial_frame_receiver.sv
// -----------------------------------------------------------------------------
// serial_frame_receiver
//
// Receive end of the interleaver hardware-test serial link. A frame starts on
// the cycle where look_now_in is high; that cycle carries bit 0, and every
// following rising edge carries the next bit. Bits are packed MSB-first into
// bytes. The frame length (SHORT_LEN or LONG_LEN bits) is chosen by
// flag_long_in on the start cycle only. A start strobe that arrives before the
// final bit of the current frame has been taken aborts that frame and begins a
// new one on the same cycle.
//
// Ports
//   clock        in   1   system clock, rising edge active
//   notreset     in   1   asynchronous active-low reset
//   dataIn       in   1   serial data bit, sampled every rising edge
//   flag_long_in in   1   frame-size select, sampled on the frame-start cycle
//   look_now_in  in   1   frame-start strobe (cycle carrying bit 0)
//   byte_out     out  8   last completed byte, first received bit in bit 7
//   byte_valid   out  1   one-cycle pulse when byte_out updates
//   frame_done   out  1   one-cycle pulse with the last byte of a frame
//   frame_long   out  1   size of current / last frame (1 = LONG_LEN)
//   frame_err    out  1   one-cycle pulse when a frame is aborted
//   frame_count  out  16  completed frames, wraps
//   err_count    out  8   aborted frames, saturates at 255
//   busy         out  1   high while a frame is being received
// -----------------------------------------------------------------------------
module serial_frame_receiver #(
    parameter int SHORT_LEN = 1056,
    parameter int LONG_LEN  = 6144,
    parameter int CNT_W     = 13
) (
    input  logic        clock,
    input  logic        notreset,
    input  logic        dataIn,
    input  logic        flag_long_in,
    input  logic        look_now_in,
    output logic [7:0]  byte_out,
    output logic        byte_valid,
    output logic        frame_done,
    output logic        frame_long,
    output logic        frame_err,
    output logic [15:0] frame_count,
    output logic [7:0]  err_count,
    output logic        busy
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RECV = 1'b1;

    // Index of the final bit of each frame size, as seen on the bit counter.
    localparam logic [CNT_W-1:0] SHORT_LAST = CNT_W'(SHORT_LEN - 1);
    localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(LONG_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [0:0]       state_q,       state_d;
    logic [6:0]       shift_q,       shift_d;
    logic [CNT_W-1:0] cnt_q,         cnt_d;
    logic [7:0]       byte_q,        byte_d;
    logic             byte_valid_q,  byte_valid_d;
    logic             frame_done_q,  frame_done_d;
    logic             frame_long_q,  frame_long_d;
    logic             frame_err_q,   frame_err_d;
    logic [15:0]      frame_count_q, frame_count_d;
    logic [7:0]       err_count_q,   err_count_d;
    logic             busy_q,        busy_d;

    logic             last_bit_s;
    logic             byte_end_s;
    logic [7:0]       err_inc_s;

    // Decode the bit position currently on dataIn within the frame in progress.
    always_comb begin
        if (frame_long_q) begin
            last_bit_s = (cnt_q == LONG_LAST);
        end else begin
            last_bit_s = (cnt_q == SHORT_LAST);
        end
        byte_end_s = (cnt_q[2:0] == 3'd7);
        if (err_count_q == 8'hFF) begin
            err_inc_s = err_count_q;
        end else begin
            err_inc_s = err_count_q + 8'd1;
        end
    end

    // Next-state logic for the receive FSM and all registered outputs.
    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        cnt_d         = cnt_q;
        byte_d        = byte_q;
        byte_valid_d  = 1'b0;
        frame_done_d  = 1'b0;
        frame_long_d  = frame_long_q;
        frame_err_d   = 1'b0;
        frame_count_d = frame_count_q;
        err_count_d   = err_count_q;

        case (state_q)
            ST_IDLE: begin
                if (look_now_in) begin
                    // Bit 0 of a new frame; older shift contents are pushed
                    // out before the first byte boundary is reached.
                    shift_d      = {shift_q[5:0], dataIn};
                    cnt_d        = CNT_ONE;
                    frame_long_d = flag_long_in;
                    state_d      = ST_RECV;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RECV: begin
                if (look_now_in) begin
                    // Early strobe: drop the partial frame and restart with the
                    // current bit as bit 0. No byte or frame pulse this edge.
                    frame_err_d  = 1'b1;
                    err_count_d  = err_inc_s;
                    shift_d      = {shift_q[5:0], dataIn};
                    cnt_d        = CNT_ONE;
                    frame_long_d = flag_long_in;
                    state_d      = ST_RECV;
                end else begin
                    shift_d = {shift_q[5:0], dataIn};
                    cnt_d   = cnt_q + CNT_ONE;
                    if (byte_end_s) begin
                        byte_d       = {shift_q, dataIn};
                        byte_valid_d = 1'b1;
                    end else begin
                        byte_valid_d = 1'b0;
                    end
                    if (last_bit_s) begin
                        frame_done_d  = 1'b1;
                        frame_count_d = frame_count_q + 16'd1;
                        cnt_d         = {CNT_W{1'b0}};
                        state_d       = ST_IDLE;
                    end else begin
                        state_d = ST_RECV;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase

        busy_d = (state_d == ST_RECV);
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clock or negedge notreset) begin
        if (!notreset) begin
            state_q       <= ST_IDLE;
            shift_q       <= 7'd0;
            cnt_q         <= {CNT_W{1'b0}};
            byte_q        <= 8'd0;
            byte_valid_q  <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_long_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            frame_count_q <= 16'd0;
            err_count_q   <= 8'd0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            cnt_q         <= cnt_d;
            byte_q        <= byte_d;
            byte_valid_q  <= byte_valid_d;
            frame_done_q  <= frame_done_d;
            frame_long_q  <= frame_long_d;
            frame_err_q   <= frame_err_d;
            frame_count_q <= frame_count_d;
            err_count_q   <= err_count_d;
            busy_q        <= busy_d;
        end
    end

    assign byte_out    = byte_q;
    assign byte_valid  = byte_valid_q;
    assign frame_done  = frame_done_q;
    assign frame_long  = frame_long_q;
    assign frame_err   = frame_err_q;
    assign frame_count = frame_count_q;
    assign err_count   = err_count_q;
    assign busy        = busy_q;

    serial_frame_receiver_chk u_chk (
        .clock      (clock),
        .notreset   (notreset),
        .byte_valid (byte_valid_q),
        .frame_done (frame_done_q),
        .frame_err  (frame_err_q),
        .busy       (busy_q)
    );

endmodule

// -----------------------------------------------------------------------------
// serial_frame_receiver_chk
//
// Output-relationship properties of the receiver.
// Ports: clock, notreset, and the byte_valid/frame_done/frame_err/busy outputs.
// -----------------------------------------------------------------------------
module serial_frame_receiver_chk (
    input logic clock,
    input logic notreset,
    input logic byte_valid,
    input logic frame_done,
    input logic frame_err,
    input logic busy
);

    a_done_with_byte : assert property (@(posedge clock) disable iff (!notreset)
        frame_done |-> byte_valid);

    a_err_no_byte : assert property (@(posedge clock) disable iff (!notreset)
        frame_err |-> !byte_valid);

    a_err_stays_busy : assert property (@(posedge clock) disable iff (!notreset)
        frame_err |-> busy);

    a_done_goes_idle : assert property (@(posedge clock) disable iff (!notreset)
        frame_done |-> !busy);

endmodule

// File: tb/tb_serial_frame_receiver.sv
// -----------------------------------------------------------------------------
// tb_serial_frame_receiver
//
// Self-checking bench for serial_frame_receiver. Frames are described by a
// table of records (size, data pattern, mid-frame flag toggling, idle gap and
// the frame count / size expected once the frame ends). Every bit driven is
// followed by a check of the per-cycle outputs against values derived from the
// bit index and the frame length. Hand-written sequences cover aborts, abort on
// the final bit, asynchronous reset mid-frame and error-counter saturation.
// -----------------------------------------------------------------------------
module tb_serial_frame_receiver;

    logic        clock = 1'b0;
    logic        notreset;
    logic        dataIn;
    logic        flag_long_in;
    logic        look_now_in;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        frame_done;
    logic        frame_long;
    logic        frame_err;
    logic [15:0] frame_count;
    logic [7:0]  err_count;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_fc   = 0;
    int exp_ec   = 0;
    bit in_recv  = 1'b0;

    typedef struct {
        bit lng;
        int pat;
        bit toggle;
        int gap;
        int exp_fc;
        bit exp_long;
    } vec_t;

    vec_t tbl[4];

    serial_frame_receiver dut (
        .clock        (clock),
        .notreset     (notreset),
        .dataIn       (dataIn),
        .flag_long_in (flag_long_in),
        .look_now_in  (look_now_in),
        .byte_out     (byte_out),
        .byte_valid   (byte_valid),
        .frame_done   (frame_done),
        .frame_long   (frame_long),
        .frame_err    (frame_err),
        .frame_count  (frame_count),
        .err_count    (err_count),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] pat_byte(input int pat, input int idx);
        int v;
        case (pat)
            0:       v = 32'hA5;
            1:       v = idx;
            default: v = idx * 59 + 17;
        endcase
        return v[7:0];
    endfunction

    task automatic drive_bit(input logic d, input logic look, input logic flag);
        dataIn       = d;
        look_now_in  = look;
        flag_long_in = flag;
        @(posedge clock);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            drive_bit(1'($urandom_range(1, 0)), 1'b0, 1'($urandom_range(1, 0)));
            chk("idle_busy", 32'(busy), 32'(0));
            chk("idle_byte_valid", 32'(byte_valid), 32'(0));
        end
    endtask

    // Sends the first nbits bits of a frame, starting with the strobe on bit 0.
    task automatic send_frame(input bit lng, input int pat, input int nbits, input bit toggle);
        int         len;
        logic [7:0] b;
        logic       flag;
        bit         was_recv;
        len = lng ? 6144 : 1056;
        for (int i = 0; i < nbits; i++) begin
            b        = pat_byte(pat, i / 8);
            was_recv = in_recv;
            flag     = (i == 0 || !toggle) ? lng : !lng;
            drive_bit(b[7 - (i % 8)], (i == 0), flag);
            if (i == 0) begin
                in_recv = 1'b1;
                if (was_recv) begin
                    exp_ec = (exp_ec < 255) ? exp_ec + 1 : 255;
                end
                chk("frame_err_start", 32'(frame_err), 32'(was_recv));
                chk("frame_long_start", 32'(frame_long), 32'(lng));
                chk("err_count", 32'(err_count), 32'(exp_ec));
            end else begin
                chk("frame_err", 32'(frame_err), 32'(0));
            end
            chk("byte_valid", 32'(byte_valid), 32'((i % 8) == 7));
            if ((i % 8) == 7) begin
                chk("byte_out", 32'(byte_out), 32'(b));
            end
            chk("frame_done", 32'(frame_done), 32'(i == len - 1));
            chk("busy", 32'(busy), 32'(i != len - 1));
            if (i == len - 1) begin
                exp_fc  = (exp_fc + 1) & 32'hFFFF;
                in_recv = 1'b0;
                chk("frame_count", 32'(frame_count), 32'(exp_fc));
                chk("frame_long_end", 32'(frame_long), 32'(lng));
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_byte_out"}, 32'(byte_out), 32'(0));
        chk({tag, "_byte_valid"}, 32'(byte_valid), 32'(0));
        chk({tag, "_frame_done"}, 32'(frame_done), 32'(0));
        chk({tag, "_frame_long"}, 32'(frame_long), 32'(0));
        chk({tag, "_frame_err"}, 32'(frame_err), 32'(0));
        chk({tag, "_frame_count"}, 32'(frame_count), 32'(0));
        chk({tag, "_err_count"}, 32'(err_count), 32'(0));
        chk({tag, "_busy"}, 32'(busy), 32'(0));
    endtask

    initial begin
        // lng, pat, toggle, gap, frame_count after, frame_long after
        tbl[0] = '{lng: 1'b0, pat: 0, toggle: 1'b0, gap: 0, exp_fc: 1, exp_long: 1'b0};
        tbl[1] = '{lng: 1'b1, pat: 1, toggle: 1'b1, gap: 2, exp_fc: 2, exp_long: 1'b1};
        tbl[2] = '{lng: 1'b0, pat: 2, toggle: 1'b0, gap: 0, exp_fc: 3, exp_long: 1'b0};
        tbl[3] = '{lng: 1'b0, pat: 0, toggle: 1'b1, gap: 0, exp_fc: 4, exp_long: 1'b0};

        notreset     = 1'b0;
        dataIn       = 1'b0;
        flag_long_in = 1'b0;
        look_now_in  = 1'b0;
        #12;
        check_all_zero("reset");
        @(negedge clock);
        notreset = 1'b1;

        // Data without a strobe is ignored.
        idle_cycles(3);

        for (int k = 0; k < 4; k++) begin
            idle_cycles(tbl[k].gap);
            send_frame(tbl[k].lng, tbl[k].pat, tbl[k].lng ? 6144 : 1056, tbl[k].toggle);
            chk("tbl_frame_count", 32'(frame_count), 32'(tbl[k].exp_fc));
            chk("tbl_frame_long", 32'(frame_long), 32'(tbl[k].exp_long));
        end

        // Abort at bit 500, restarted frame completes normally.
        send_frame(1'b0, 0, 500, 1'b0);
        send_frame(1'b0, 2, 1056, 1'b0);
        chk("abort_err_count", 32'(err_count), 32'(1));
        chk("abort_frame_count", 32'(frame_count), 32'(5));

        // Strobe on the final-bit edge aborts instead of completing.
        send_frame(1'b0, 0, 1055, 1'b0);
        send_frame(1'b0, 1, 1056, 1'b0);
        chk("lastbit_err_count", 32'(err_count), 32'(2));
        chk("lastbit_frame_count", 32'(frame_count), 32'(6));
        idle_cycles(2);

        // Asynchronous reset in the middle of a long frame.
        send_frame(1'b1, 0, 300, 1'b0);
        chk("pre_reset_busy", 32'(busy), 32'(1));
        chk("pre_reset_byte", 32'(byte_out), 32'(8'hA5));
        #2;
        notreset = 1'b0;
        #1;
        check_all_zero("midreset");
        @(negedge clock);
        notreset = 1'b1;
        in_recv  = 1'b0;
        exp_fc   = 0;
        exp_ec   = 0;
        send_frame(1'b0, 1, 1056, 1'b0);
        chk("post_reset_frame_count", 32'(frame_count), 32'(1));

        // One start from idle, then 260 aborting starts.
        for (int k = 0; k <= 260; k++) begin
            drive_bit(1'(k % 2), 1'b1, 1'b0);
            if (k > 0) begin
                exp_ec = (exp_ec < 255) ? exp_ec + 1 : 255;
            end
            chk("sat_frame_err", 32'(frame_err), 32'(k > 0));
            chk("sat_err_count", 32'(err_count), 32'(exp_ec));
        end
        chk("sat_final", 32'(err_count), 32'(255));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_frame_receiver.md
Name: serial_frame_receiver

Overview:
- Receive end of the interleaver hardware-test serial link. Accepts the 1-bit serial stream plus the frame-size flag and the frame-start strobe.
- Deserializes each frame MSB-first into bytes, tracks frame length and framing errors, and counts completed frames.
- Sits on the loop-back path of the hardware test harness, driving the byte stream and status LEDs.

Parameters:
- SHORT_LEN, 1056, frame length in bits when flag_long_in is 0 at frame start; must be a multiple of 8.
- LONG_LEN, 6144, frame length in bits when flag_long_in is 1 at frame start; must be a multiple of 8.
- CNT_W, 13, bit-counter width; must hold LONG_LEN-1.

Ports:
- clock  input  1  system clock, rising-edge active
- notreset  input  1  asynchronous active-low reset
- dataIn  input  1  serial data bit, sampled every rising edge
- flag_long_in  input  1  frame-size select, sampled only on the frame-start cycle
- look_now_in  input  1  frame-start strobe; high for the cycle carrying bit 0 of a frame
- byte_out  output  8  last completed byte; first received bit lands in bit 7
- byte_valid  output  1  one-cycle pulse when byte_out is updated
- frame_done  output  1  one-cycle pulse when the last byte of a frame is delivered
- frame_long  output  1  size of the frame in progress or last completed (1 = LONG_LEN)
- frame_err  output  1  one-cycle pulse when a frame is aborted by an early look_now_in
- frame_count  output  16  completed frames, wraps at 16 bits
- err_count  output  8  aborted frames, saturates at 255
- busy  output  1  high while in RECV

Behaviour:
- Reset (notreset=0, asynchronous):
  - State goes to IDLE.
  - byte_out=0, byte_valid=0, frame_done=0, frame_long=0, frame_err=0, frame_count=0, err_count=0, busy=0.
  - Shift register and bit counter are cleared.
- Asserting reset mid-frame discards the partial frame with no pulses. Deassertion takes effect on the next rising edge.
- All outputs are registered. Pulses are high for exactly one cycle following the edge that caused them.
- IDLE:
  - dataIn is ignored until look_now_in=1.
  - On that edge: capture dataIn as bit 0, latch frame_long<=flag_long_in, set bit counter=1, go to RECV, busy=1.
- RECV, each edge:
  - Shift dataIn into the shift register and increment the counter.
  - On the edge sampling bit 8k+7: byte_out <= {shift[6:0], dataIn} and byte_valid pulses.
  - Latency: the byte appears in the cycle immediately after its 8th bit is sampled.
- Frame end: on the edge sampling bit LEN-1 (LEN = LONG_LEN or SHORT_LEN by the latched frame_long):
  - The final byte_valid and frame_done pulse together.
  - frame_count increments (wraps 0xFFFF->0).
  - State returns to IDLE and busy=0.
- Back-to-back frames: look_now_in=1 on the cycle right after the last bit is accepted as a new frame start with no gap.
- Early strobe: look_now_in=1 in RECV on any edge before bit LEN-1 is sampled (bit counter 1..LEN-1) is an abort.
  - frame_err pulses and err_count increments, saturating at 255.
  - The partial byte is discarded; no byte_valid or frame_done on that edge.
  - The receiver resynchronizes: the current dataIn becomes bit 0 of a new frame, flag_long_in is re-latched, counter=1, state stays RECV.
- look_now_in=1 on the final-bit edge is also an abort: the final byte is not delivered and frame_done does not pulse.
- flag_long_in changes mid-frame are ignored.
- frame_long holds its value in IDLE until the next frame start.

Test Plan:
- Reset then look_now_in=1 with flag_long_in=0, stream 1056 bits of pattern 0xA5 repeating MSB-first -> 132 byte_valid pulses, each byte_out=0xA5 and 8 cycles apart. frame_done coincides with byte 132, frame_count=1, busy low the cycle after.
- Long frame: flag_long_in=1 at start, incrementing bytes 0x00..0xFF repeating -> 768 bytes in order, frame_long=1, frame_done after bit 6143. Toggling flag_long_in mid-frame has no effect.
- Back-to-back: two short frames with look_now_in on the cycle after the last bit -> frame_count=2, no frame_err, no idle cycle needed.
- Abort: look_now_in re-asserted at bit 500 of a short frame -> frame_err pulse, err_count=1, no frame_done. The new frame completes 1056 bits later with frame_count=1.
- Reset mid-frame at bit 300 -> all outputs 0 immediately (asynchronous). A subsequent clean frame is received correctly.
- err_count saturation: 260 aborted starts -> err_count holds at 255 and frame_err still pulses each abort.
